// File: rtl/im_loader.sv
// +----------------------------------------------------------------------------+
// | im_loader - packs a byte stream little-endian into 32-bit instruction-     |
// | memory writes. Optional running checksum: IM_LOADER_CHECKSUM_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module im_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [8:0]        load_words,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold,
   output logic [8:0]        word_cnt,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [8:0] C_MAX = 9'(MAX_WORDS);

   state_t      state;
   state_t      state_nx;
   logic [8:0]  target;
   logic [1:0]  idx;
   logic [23:0] lanes;
   logic        start_ok;
   logic [8:0]  cnt_inc;

   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
   assign cnt_inc  = word_cnt + 9'd1;
   assign cpu_hold = busy;

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      im_we      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            done = (state == S_DONE);
            // A zero-length request completes without ever raising busy.
            if (start) begin
               state_nx = (load_words == 9'd0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && (idx == 2'd3)) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            im_we    = 1'b1;
            busy     = 1'b1;
            state_nx = (cnt_inc == target) ? S_DONE : S_COLLECT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         target   <= 9'd0;
         word_cnt <= 9'd0;
         idx      <= 2'd0;
         lanes    <= 24'd0;
         im_addr  <= '0;
         im_wdata <= 32'd0;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            target   <= (load_words > C_MAX) ? C_MAX : load_words;
            word_cnt <= 9'd0;
            idx      <= 2'd0;
            im_addr  <= '0;
         end else if ((state == S_COLLECT) && byte_valid) begin
            idx <= idx + 2'd1;
            case (idx)
               2'd0: lanes[7:0]   <= byte_data;
               2'd1: lanes[15:8]  <= byte_data;
               2'd2: lanes[23:16] <= byte_data;
               2'd3: begin
                  // Address and data are registered so they hold through WRITE.
                  im_wdata <= {byte_data, lanes};
                  im_addr  <= ADDR_W'({word_cnt, 2'b00});
               end
            endcase
         end else if (state == S_WRITE) begin
            word_cnt <= cnt_inc;
            idx      <= 2'd0;
         end
      end
   end

`ifdef IM_LOADER_CHECKSUM_EN
   logic [31:0] sum;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum <= 32'd0;
      end else if (start_ok) begin
         sum <= 32'd0;
      end else if (state == S_WRITE) begin
         sum <= sum + im_wdata;
      end
   end

   assign checksum = sum;
`else
   assign checksum = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/im_loader.md
# im_loader

Writes a program image into the byte-organised instruction memory from a byte stream, so the memory can be loaded at run time instead of only at simulation start. It takes bytes over a valid/ready handshake and packs them little-endian: the first byte received becomes bits [7:0] of the word. Each complete word goes out on a one-cycle byte-addressed write port. The block sits between a host or UART byte source and the instruction-memory write side, and holds the CPU while a load is in progress.

## Interface
- `ADDR_W`, default 10: byte-address width of the instruction memory.
- `MAX_WORDS`, default 256: maximum number of words per load (1024 bytes).
- `clk` in 1: clock; every register updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: begins a load when sampled high in IDLE or DONE.
- `load_words` in 9: number of words to load, sampled when `start` is accepted.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_data` in 8: incoming byte.
- `byte_ready` out 1: the block can accept a byte this cycle.
- `im_we` out 1: instruction-memory write strobe, one cycle per word.
- `im_addr` out ADDR_W: word-aligned byte address; bits [1:0] are always 0.
- `im_wdata` out 32: packed word, `{b3,b2,b1,b0}`.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed.
- `cpu_hold` out 1: equal to `busy`; stalls or resets the pipeline.
- `word_cnt` out 9: words written so far in the current load.
- `checksum` out 32: see Configuration.

## Operation
- Byte handshake:
  - A byte is accepted on a rising edge where `byte_valid` and `byte_ready` are both 1.
  - `byte_data` may change only after the byte is accepted.
- States:
  - IDLE: `byte_ready`=0. On `start`: latch `min(load_words, MAX_WORDS)` as the target and clear `word_cnt`, the byte index and the address. If the target is 0, go to DONE; otherwise go to COLLECT.
  - COLLECT: `byte_ready`=1. Each accepted byte goes into lane `idx` of the assembly register and `idx` increments. When the byte for `idx`=3 is accepted, go to WRITE.
  - WRITE: `byte_ready`=0.
    - Outputs: `im_we`=1, `im_addr` = 4*`word_cnt`, `im_wdata` = the assembled word.
    - Next edge: `word_cnt`+1 and `idx`←0.
    - If the new `word_cnt` equals the target, go to DONE; otherwise go to COLLECT.
  - DONE: `done`=1 and `byte_ready`=0. Bytes offered here are not accepted. `start` restarts the load exactly as from IDLE.
- `start` outside IDLE/DONE is ignored.
- `busy` is 1 in COLLECT and WRITE.
- Address arithmetic:
  - `im_addr` = {`word_cnt`[ADDR_W-3:0], 2'b00}.
  - With the target clamped to MAX_WORDS, the address never wraps; the last word goes to byte address 1020.
- Reset, including mid-load:
  - State goes to IDLE.
  - `byte_ready`, `im_we`, `busy`, `done` and `cpu_hold` go to 0.
  - `im_addr`, `im_wdata`, `word_cnt` and `checksum` go to 0.
  - A partially assembled word is discarded and never written.

## Timing
- `im_we` is high exactly one cycle, the cycle after the edge that accepted byte 3 of a word.
- `im_addr` and `im_wdata` are registered and stable throughout that cycle. Outside WRITE, `im_wdata` holds its last value.
- Peak throughput: 4 bytes per 5 cycles. `byte_ready` drops for the WRITE cycle only.
- The edge that accepts `start` changes state, so `byte_ready` is 1 in the first cycle after `start`.
- After the final write, `done` rises on the next edge (the cycle after the `im_we` pulse). On that same edge `busy` and `cpu_hold` fall.
- The target, `word_cnt` and `checksum` are all sampled or updated on the clock edge.

## Configuration
- `IM_LOADER_CHECKSUM_EN`
  - Defined:
    - `checksum` is a running 32-bit sum, modulo 2^32, of every written word.
    - It is cleared when `start` is accepted and updated on the WRITE edge.
    - It is stable in DONE.
  - Undefined: `checksum` is tied to 32'h0 and no accumulator is built.

## Test plan
- Reset, then `start` with `load_words`=2 and bytes 78 56 34 12 EF BE AD DE sent back-to-back. Expected:
  - `im_we` pulses twice: addr 0 / data 32'h12345678, then addr 4 / data 32'hDEADBEEF.
  - `done`=1 and `word_cnt`=2.
  - With `IM_LOADER_CHECKSUM_EN`, `checksum`=32'hF0E21567.
- `load_words`=0 → DONE on the next edge, no `im_we` pulse, `busy` never rises.
- `load_words`=300 → the target is clamped to 256. The last write is at addr 1020, then `done`; a 1025th byte offered is not accepted.
- Random `byte_valid` gaps and `byte_valid` held high during WRITE → no byte is lost or duplicated. Each word is written only after all 4 of its bytes are accepted.
- `rstn` asserted after 2 bytes of word 1 (word 0 already written) → every output returns to 0. A following `start` with `load_words`=1 writes to addr 0 with fresh bytes, and no stale lanes appear in the word.
- `start` pulsed while in COLLECT → ignored, with the target, `word_cnt` and address unchanged. `start` in DONE restarts the load, and `checksum` is reset.
